// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_ctrl_pkg;

    typedef enum logic {
        HZ_IDLE = 1'b0,
        HZ_WAIT = 1'b1
    } hazard_state_e;

    localparam int unsigned IFETCH_IDX     = 0;
    localparam int unsigned DEF_REG_ADDR_W = 5;

    typedef logic [DEF_REG_ADDR_W-1:0] reg_idx_t;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_mem_tracker.sv
// Per-port outstanding-read tracker: IDLE/WAIT FSM, saturating wait counter, sticky timeout.
module hazard_mem_tracker
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic read_v_i,
    input  logic resp_v_i,
    output logic mem_stall_c,
    output logic timeout_v_o
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    hazard_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= HZ_IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            HZ_IDLE: begin
                if (read_v_i && !resp_v_i) begin
                    state_d = HZ_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            HZ_WAIT: begin
                if (resp_v_i) begin
                    state_d = HZ_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = HZ_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Flag lands together with the counter reaching the limit.
        if (state_d == HZ_WAIT && cnt_d == CNT_MAX) begin
            timeout_d = 1'b1;
        end
    end

    assign mem_stall_c = read_v_i & ~resp_v_i;
    assign timeout_v_o = timeout_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls, oldest-wins redirect flushes, load-use bubbles.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES      = 6,
    parameter int unsigned NUM_MEM_PORTS   = 2,
    parameter int unsigned REG_ADDR_W      = 5,
    parameter int unsigned DECODE_IDX      = 1,
    parameter int unsigned RFETCH_IDX      = 2,
    parameter int unsigned LOAD_USE_CYCLES = 1,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [NUM_MEM_PORTS-1:0] mem_read_v_i,
    input  logic [NUM_MEM_PORTS-1:0] mem_resp_v_i,
    input  logic [NUM_STAGES-1:0]    br_v_i,
    input  logic                     load_v_i,
    input  logic [REG_ADDR_W-1:0]    load_rd_i,
    input  logic                     dec_rs1_v_i,
    input  logic                     dec_rs2_v_i,
    input  logic [REG_ADDR_W-1:0]    dec_rs1_i,
    input  logic [REG_ADDR_W-1:0]    dec_rs2_i,
    output logic [NUM_STAGES-1:0]    stall_v_o,
    output logic [NUM_STAGES-1:0]    flush_v_o,
    output logic                     bubble_v_o,
    output logic [NUM_MEM_PORTS-1:0] timeout_v_o
);

    localparam int unsigned IDX_W = cnt_width(NUM_STAGES - 1);
    localparam int unsigned LU_W  = cnt_width(LOAD_USE_CYCLES);
    localparam logic [LU_W-1:0]  LU_RELOAD = LU_W'(LOAD_USE_CYCLES - 1);
    localparam logic [IDX_W-1:0] DEC_IDX   = IDX_W'(DECODE_IDX);

    logic [NUM_MEM_PORTS-1:0] mem_stall_c;
    logic                     mem_stall_any;
    logic [IDX_W-1:0]         new_idx;
    logic [IDX_W-1:0]         eff_idx;
    logic [IDX_W-1:0]         pend_q, pend_d;
    logic                     hazard_c;
    logic                     lu_active;
    logic [LU_W-1:0]          lu_cnt_q, lu_cnt_d;

    for (genvar p = 0; p < NUM_MEM_PORTS; p++) begin : g_port
        hazard_mem_tracker #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_trk (
            .clk_i       (clk_i),
            .reset_n_i   (reset_n_i),
            .read_v_i    (mem_read_v_i[p]),
            .resp_v_i    (mem_resp_v_i[p]),
            .mem_stall_c (mem_stall_c[p]),
            .timeout_v_o (timeout_v_o[p])
        );
    end

    assign mem_stall_any = |mem_stall_c;

    // Highest resolving stage is the oldest instruction; ifetch cannot redirect.
    always_comb begin
        new_idx = '0;
        for (int unsigned k = IFETCH_IDX + 1; k < NUM_STAGES; k++) begin
            if (br_v_i[k]) begin
                new_idx = IDX_W'(k);
            end
        end
    end

    assign eff_idx = (new_idx > pend_q) ? new_idx : pend_q;
    assign pend_d  = mem_stall_any ? eff_idx : '0;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pend_q   <= '0;
            lu_cnt_q <= '0;
        end else begin
            pend_q   <= pend_d;
            lu_cnt_q <= lu_cnt_d;
        end
    end

    assign hazard_c = load_v_i && (load_rd_i != '0) &&
                      ((dec_rs1_v_i && (dec_rs1_i == load_rd_i)) ||
                       (dec_rs2_v_i && (dec_rs2_i == load_rd_i)));
    assign lu_active = hazard_c || (lu_cnt_q != '0);

    // Remaining extra load-use cycles; frozen under a memory stall.
    always_comb begin
        lu_cnt_d = lu_cnt_q;
        if (mem_stall_any) begin
            lu_cnt_d = lu_cnt_q;
        end else if (eff_idx > DEC_IDX) begin
            lu_cnt_d = '0;
        end else if (lu_cnt_q != '0) begin
            lu_cnt_d = lu_cnt_q - LU_W'(1);
        end else if (hazard_c) begin
            lu_cnt_d = LU_RELOAD;
        end
    end

    always_comb begin
        stall_v_o = '0;
        flush_v_o = '0;
        if (reset_n_i) begin
            if (mem_stall_any) begin
                stall_v_o = '1;
            end else if (eff_idx != '0) begin
                for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                    flush_v_o[k] = (IDX_W'(k) < eff_idx);
                end
            end else if (lu_active) begin
                for (int unsigned k = 0; k <= DECODE_IDX; k++) begin
                    stall_v_o[k] = 1'b1;
                end
                flush_v_o[RFETCH_IDX] = 1'b1;
            end
        end
    end

    assign bubble_v_o = |flush_v_o;

endmodule
